stopwatch_control: RTL
======================

// Module: stopwatch_control
// PURPOSE
//   Front-end controller upstream of the stopwatch sub-second counter. Debounces the two
//   raw push-buttons and runs the stopwatch mode FSM. Drives the counter's count_enable
//   and (active-high) reset, plus a display-freeze flag for lap mode.
//   Runs entirely in the clk_10000Hz domain.
// PARAMETERS
//   DEBOUNCE_TICKS  200  consecutive stable cycles required to accept a level change (20 ms @10 kHz); >=2
//   CNT_W           8    debounce counter width; must satisfy 2**CNT_W > DEBOUNCE_TICKS
// PORTS
//   clk_10000Hz     in   1  sole clock, 10 kHz
//   reset_n         in   1  asynchronous, active-low reset
//   btn_start_stop  in   1  raw button, async, active-high, bouncy
//   btn_lap_clear   in   1  raw button, async, active-high, bouncy
//   count_enable    out  1  high while the counter must advance (RUN, LAP)
//   counter_reset   out  1  one-cycle active-high pulse that clears the counter
//   display_freeze  out  1  high in LAP: display holds the last latched value
//   mode            out  2  current state code (IDLE=0, RUN=1, LAP=2, STOP=3)
// BEHAVIOUR
//   Reset: all flops clear asynchronously on reset_n low. State=IDLE; all outputs 0;
//     debounced levels 0; sync flops 0; debounce counters 0. Release is synchronous to the clock.
//   Per button:
//     - 2-flop synchroniser.
//     - Debounce counter: increments each cycle sync_out != stable_level; returns to 0 on any
//       cycle they match.
//     - When the counter would reach DEBOUNCE_TICKS, stable_level toggles and the counter returns to 0.
//     - press pulse = stable_level & ~stable_level_d (one cycle, on rising edge only).
//       Releases generate no pulse.
//   Latency: raw rise held steady from cycle 0 -> press pulse high in cycle DEBOUNCE_TICKS+3
//     -> registered outputs and mode update at cycle DEBOUNCE_TICKS+4. This is exact.
//   Glitches shorter than DEBOUNCE_TICKS cycles never produce a pulse.
//   FSM transitions (ss = start_stop pulse, lc = lap_clear pulse):
//     IDLE --ss--> RUN    IDLE --lc--> IDLE (ignored)
//     RUN  --ss--> STOP   RUN  --lc--> LAP
//     LAP  --ss--> STOP   LAP  --lc--> RUN
//     STOP --ss--> RUN (resume, no clear)
//     STOP --lc--> IDLE, with counter_reset=1 for exactly that one cycle
//   Simultaneous ss and lc in one cycle: ss wins; lc is discarded, not queued.
//   Registered outputs are decoded from the next state:
//     - count_enable = (RUN|LAP)
//     - display_freeze = LAP
//     - counter_reset high only on the STOP->IDLE transition cycle
//   counter_reset is never asserted together with count_enable.
//   A held button produces exactly one pulse; no auto-repeat.
//   Reset mid-debounce or mid-LAP: everything returns to reset values; the partial count is lost.
//   A button still held when reset_n deasserts is accepted as a new press after the full
//     debounce time.
//   Mode codes are fixed: 0 IDLE, 1 RUN, 2 LAP, 3 STOP. Unreachable encodings do not exist (2-bit, all used).
// STRUCTURE
//   Shared include stopwatch_defs.vh:
//     - localparams for the mode codes (MODE_IDLE/RUN/LAP/STOP)
//     - CLK_HZ=10000
//     - counter terminal value 10000, shared with the counter and display stages
//   Sub-module button_debounce (synchroniser + debounce counter + edge pulse), instantiated
//     once per button and parameterised by DEBOUNCE_TICKS and CNT_W.
//   The FSM and output registers stay in the top module.
// TESTING (bench uses DEBOUNCE_TICKS=4)
//   1. Reset held, buttons toggling -> mode=0, count_enable=0, counter_reset=0, display_freeze=0 throughout.
//   2. ss held high from cycle 0 after reset -> mode=1 and count_enable=1 at cycle 8; no further change while held.
//   3. ss bouncing 1,0,1,0 at 1-cycle intervals then steady 1 -> exactly one transition, at
//      cycle 8 after the final steady edge.
//   4. Sequence RUN -> lc -> ss -> lc:
//      - mode 1->2: display_freeze=1, count_enable stays 1
//      - then 2->3: both outputs 0
//      - then 3->0: counter_reset=1 for exactly 1 cycle
//   5. ss and lc rising together in RUN -> mode=3 (STOP); LAP not entered; no deferred LAP afterwards.
//   6. reset_n pulsed low while in LAP with lc mid-debounce -> immediate mode=0 and all
//      outputs 0; no pulse is emitted after release unless the button stays held a full
//      debounce period.

Source files
------------

// File: rtl/stopwatch_control_pkg.sv
// Shared constants for the stopwatch front-end: mode codes, clock rate and
// the sub-second counter terminal value used by the counter and display stages.
package stopwatch_control_pkg;

    // Mode codes are fixed; all four 2-bit encodings are in use.
    typedef enum logic [1:0] {
        MODE_IDLE = 2'd0,
        MODE_RUN  = 2'd1,
        MODE_LAP  = 2'd2,
        MODE_STOP = 2'd3
    } mode_e;

    localparam int CLK_HZ         = 10000;
    localparam int COUNT_TERMINAL = 10000;

endpackage : stopwatch_control_pkg

// File: rtl/stopwatch_control_button_debounce.sv
// Button front-end: 2-flop synchroniser, debounce counter and a registered
// one-cycle press pulse on each accepted rising level change.
// A raw rise held from cycle 0 gives press_o high in cycle DEBOUNCE_TICKS+3.
module stopwatch_control_button_debounce #(
    parameter int DEBOUNCE_TICKS = 200,
    parameter int CNT_W          = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic press_o
);

    // Counter value on which the next mismatching cycle completes the debounce window.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             stable_q;
    logic             stable_d;
    logic             stable_dly_q;
    logic             press_q;

    // Bring the asynchronous button into the clock domain.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
        end
    end

    // Count consecutive cycles the synchronised input disagrees with the accepted level.
    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = ~stable_q;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Debounce state and the registered rising-edge pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q        <= '0;
            stable_q     <= 1'b0;
            stable_dly_q <= 1'b0;
            press_q      <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            press_q      <= stable_q & ~stable_dly_q;
        end
    end

    assign press_o = press_q;

endmodule : stopwatch_control_button_debounce

// File: rtl/stopwatch_control.sv
// Stopwatch mode controller: debounces start/stop and lap/clear buttons and
// runs the IDLE/RUN/LAP/STOP FSM. Outputs are registered and decoded from the
// next state, so they change in the same cycle as mode.
// Handshake: none; each press is a one-cycle pulse consumed in the cycle it
// is high. A start/stop press wins over a same-cycle lap/clear press, which
// is dropped rather than deferred.
// DEBOUNCE_TICKS must be >= 2 and 2**CNT_W must exceed it.
module stopwatch_control
    import stopwatch_control_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = 200,
    parameter int CNT_W          = 8
) (
    input  logic       clk_10000Hz,
    input  logic       reset_n,
    input  logic       btn_start_stop,
    input  logic       btn_lap_clear,
    output logic       count_enable,
    output logic       counter_reset,
    output logic       display_freeze,
    output logic [1:0] mode
);

    logic  ss_press;
    logic  lc_press;
    mode_e state_q;
    mode_e state_d;
    logic  count_enable_q;
    logic  count_enable_d;
    logic  counter_reset_q;
    logic  counter_reset_d;
    logic  display_freeze_q;
    logic  display_freeze_d;

    stopwatch_control_button_debounce #(
        .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
        .CNT_W          (CNT_W)
    ) u_db_start_stop (
        .clk_i   (clk_10000Hz),
        .rst_ni  (reset_n),
        .btn_i   (btn_start_stop),
        .press_o (ss_press)
    );

    stopwatch_control_button_debounce #(
        .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
        .CNT_W          (CNT_W)
    ) u_db_lap_clear (
        .clk_i   (clk_10000Hz),
        .rst_ni  (reset_n),
        .btn_i   (btn_lap_clear),
        .press_o (lc_press)
    );

    // Next-state and next-output decode; start/stop has priority over lap/clear.
    always_comb begin
        state_d         = state_q;
        counter_reset_d = 1'b0;
        if (ss_press) begin
            unique case (state_q)
                MODE_IDLE: state_d = MODE_RUN;
                MODE_RUN:  state_d = MODE_STOP;
                MODE_LAP:  state_d = MODE_STOP;
                MODE_STOP: state_d = MODE_RUN;
                default:   state_d = MODE_IDLE;
            endcase
        end else if (lc_press) begin
            unique case (state_q)
                MODE_IDLE: state_d = MODE_IDLE;
                MODE_RUN:  state_d = MODE_LAP;
                MODE_LAP:  state_d = MODE_RUN;
                MODE_STOP: begin
                    state_d         = MODE_IDLE;
                    counter_reset_d = 1'b1;
                end
                default:   state_d = MODE_IDLE;
            endcase
        end
        count_enable_d   = (state_d == MODE_RUN) || (state_d == MODE_LAP);
        display_freeze_d = (state_d == MODE_LAP);
    end

    // State and output registers.
    always_ff @(posedge clk_10000Hz or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= MODE_IDLE;
            count_enable_q   <= 1'b0;
            counter_reset_q  <= 1'b0;
            display_freeze_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            count_enable_q   <= count_enable_d;
            counter_reset_q  <= counter_reset_d;
            display_freeze_q <= display_freeze_d;
        end
    end

    assign mode           = state_q;
    assign count_enable   = count_enable_q;
    assign counter_reset  = counter_reset_q;
    assign display_freeze = display_freeze_q;

endmodule : stopwatch_control
